// File: rtl/pixel_packer_pkg.sv
// Shared widths, packed FIFO word type and frame-size helper for pixel_packer.
package pixel_packer_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = LANES * BYTE_W;

  typedef struct packed {
    logic              last;
    logic [WORD_W-1:0] data;
  } word_t;

  function automatic int unsigned frame_pixels(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

endpackage

// File: rtl/pixel_packer_if.sv
// Pixel input stream and packed-word valid/ready output stream of pixel_packer.
interface pixel_packer_if
  import pixel_packer_pkg::*;
;
  logic              in_valid;
  logic [WORD_W-1:0] in_pixel;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  modport master (
    input  in_valid, in_pixel, out_ready,
    output out_valid, out_data, out_last
  );

  modport slave (
    output in_valid, in_pixel, out_ready,
    input  out_valid, out_data, out_last
  );
endinterface

// File: rtl/pixel_packer_fifo.sv
// First-word-fall-through word FIFO; a push into a full FIFO succeeds only with a same-cycle pop.
module pixel_packer_fifo
  import pixel_packer_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_push,
  input  word_t         i_data,
  input  logic          i_pop,
  output word_t         o_head,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  word_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_wr;

  assign w_pop = i_pop && (r_count != '0);
  assign w_wr  = i_push && ((r_count != CW'(DEPTH)) || w_pop);

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/pixel_packer.sv
// Reduces processor pixels to bytes, packs four per word, and queues words with frame-end marking.
// Optional build macro PIXEL_PACKER_SATURATE_EN selects signed clamping instead of truncation.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter  int unsigned IMG_WIDTH  = 32,
  parameter  int unsigned IMG_HEIGHT = 32,
  parameter  int unsigned FIFO_DEPTH = 8,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  pixel_packer_if.master    bus,
  output logic              overflow,
  input  logic              clr_overflow,
  output logic              frame_done,
  output logic [CNT_W-1:0]  fill_level
);

  localparam int unsigned NPIX   = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
  localparam int unsigned PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned LANE_W = $clog2(LANES);

  logic [BYTE_W-1:0] w_byte;
  logic [LANE_W-1:0] r_lane;
  logic [PIX_W-1:0]  r_pix;
  logic [WORD_W-1:0] r_word;
  logic [WORD_W-1:0] w_word;
  logic              w_eof;
  logic              w_push;
  logic              w_drop;
  logic              w_full;
  logic              w_empty;
  word_t             w_push_word;
  word_t             w_head;

`ifdef PIXEL_PACKER_SATURATE_EN
  // Signed clamp to 0..255.
  always_comb begin
    if (bus.in_pixel[WORD_W-1])               w_byte = '0;
    else if (|bus.in_pixel[WORD_W-2:BYTE_W])  w_byte = '1;
    else                                      w_byte = bus.in_pixel[BYTE_W-1:0];
  end
`else
  logic w_unused_hi;
  assign w_byte      = bus.in_pixel[BYTE_W-1:0];
  assign w_unused_hi = ^bus.in_pixel[WORD_W-1:BYTE_W];
`endif

  assign w_eof  = (r_pix == PIX_W'(NPIX - 1));
  assign w_push = bus.in_valid && ((r_lane == LANE_W'(LANES - 1)) || w_eof);

  // Current partial word with this pixel's byte merged into its lane.
  always_comb begin
    w_word = r_word;
    for (int k = 0; k < int'(LANES); k++) begin
      if (r_lane == LANE_W'(k)) w_word[k*BYTE_W +: BYTE_W] = w_byte;
    end
  end

  assign w_push_word.last = w_eof;
  assign w_push_word.data = w_word;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lane <= '0;
      r_pix  <= '0;
      r_word <= '0;
    end else if (bus.in_valid) begin
      r_lane <= w_push ? '0 : r_lane + LANE_W'(1);
      r_pix  <= w_eof  ? '0 : r_pix + PIX_W'(1);
      r_word <= w_push ? '0 : w_word;
    end
  end

  pixel_packer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  (w_push_word),
    .i_pop   (bus.out_ready),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fill_level)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head.data;
  assign bus.out_last  = w_head.last;

  // A word is lost only when full and the sink does not pop this cycle.
  assign w_drop = w_push && w_full && !bus.out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (w_drop)            overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
      frame_done <= bus.in_valid && w_eof;
    end
  end

endmodule
